// File: rtl/reaction_controller.sv
// ---------------------------------------------------------------------------
// reaction_controller
//
// Round sequencer for the reaction game. Each round: arm on btnS, wait a
// pseudo-random number of milliseconds, light "go", measure the reaction
// time in ms, then report the result or a false start. Drives the
// number/mode/select inputs of the display block.
//
// Parameters
//   TICK_DIV     clk cycles per 1 ms tick
//   MIN_WAIT_MS  minimum random delay before "go", in ms
//
// Ports
//   clk         system clock, all state on its rising edge
//   rst         asynchronous active-low reset (release synchronous to clk)
//   btnS        start / react / acknowledge (asynchronous to clk)
//   btnU        toggles result view between last and best time
//   btnD        clears best time
//   number      display value, 0..9999
//   mode        0 IDLE, 1 WAIT, 2 GO, 3 RESULT/FAULT
//   select      in mode 3: 1 = fault (blink) or best-time view
//   go          high only in GO
//   round_done  one-cycle pulse on the first cycle in RESULT or FAULT
//
// Output event semantics: round_done acts as a valid strobe with no ready.
// It is high for exactly one cycle, and number/mode/select presented in that
// same cycle are the round outcome; the consumer must sample them then or
// later while mode stays 3. There is no back-pressure.
// ---------------------------------------------------------------------------
module reaction_controller #(
    parameter int TICK_DIV    = 100000,
    parameter int MIN_WAIT_MS = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        btnS,
    input  logic        btnU,
    input  logic        btnD,
    output logic [13:0] number,
    output logic [1:0]  mode,
    output logic        select,
    output logic        go,
    output logic        round_done
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_WAIT   = 3'd1,
        S_GO     = 3'd2,
        S_RESULT = 3'd3,
        S_FAULT  = 3'd4
    } state_t;

    localparam int              PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0]   TICK_LAST  = PW'(TICK_DIV - 1);
    localparam logic [12:0]     MIN_WAIT   = 13'(MIN_WAIT_MS);
    localparam logic [13:0]     MS_MAX     = 14'd9999;
    localparam logic [13:0]     MS_PRE_MAX = 14'd9998;
    localparam logic [15:0]     LFSR_SEED  = 16'hACE1;
    // Galois taps for x^16 + x^14 + x^13 + x^11 + 1 (right-shifting form).
    localparam logic [15:0]     LFSR_TAPS  = 16'hB400;

    state_t         state_q, state_d;
    logic [2:0]     sync1_q, sync2_q, prev_q;
    logic [15:0]    lfsr_q, lfsr_d;
    logic [PW-1:0]  presc_q, presc_d;
    logic [12:0]    wait_q, wait_d;
    logic [13:0]    ms_q, ms_d;
    logic [13:0]    last_q, last_d;
    logic [13:0]    best_q, best_d;
    logic           view_q, view_d;

    logic [13:0]    number_d;
    logic [1:0]     mode_d;
    logic           select_d, go_d, round_done_d;

    logic [2:0]     btn_rise;
    logic           rise_s, rise_u, rise_d;
    logic           tick;

    // Bit order in the synchronizer vectors: {btnD, btnU, btnS}.
    assign btn_rise = sync2_q & ~prev_q;
    assign rise_s   = btn_rise[0];
    assign rise_u   = btn_rise[1];
    assign rise_d   = btn_rise[2];
    assign tick     = (presc_q == TICK_LAST);

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        ms_d    = ms_q;
        last_d  = last_q;
        best_d  = best_q;
        view_d  = view_q;

        lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);

        case (state_q)
            S_IDLE: begin
                if (rise_s) begin
                    wait_d  = MIN_WAIT + 13'(lfsr_q[11:0]);
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                // A press always wins over a coinciding expiry.
                if (rise_s) begin
                    state_d = S_FAULT;
                end else if (tick) begin
                    wait_d = wait_q - 13'd1;
                    if (wait_q <= 13'd1) begin
                        state_d = S_GO;
                        ms_d    = 14'd0;
                    end
                end
            end
            S_GO: begin
                // The press latches the pre-increment count, even if a tick
                // lands on the same cycle.
                if (rise_s) begin
                    last_d  = ms_q;
                    state_d = S_RESULT;
                end else if (tick) begin
                    if (ms_q == MS_PRE_MAX) begin
                        ms_d    = MS_MAX;
                        last_d  = MS_MAX;
                        state_d = S_RESULT;
                    end else begin
                        ms_d = ms_q + 14'd1;
                    end
                end
            end
            S_RESULT: begin
                if (rise_u) view_d = ~view_q;
                if (rise_d) best_d = MS_MAX;
                if (rise_s) state_d = S_IDLE;
            end
            S_FAULT: begin
                if (rise_s) state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Entry into RESULT: fold the new time into best and show last.
        if (state_d == S_RESULT && state_q != S_RESULT) begin
            view_d = 1'b0;
            if (last_d < best_q) best_d = last_d;
        end

        // Restarting the prescaler on every state change makes the first
        // ms of each state a full ms.
        if (state_d != state_q || tick) presc_d = '0;
        else                            presc_d = presc_q + PW'(1);
    end

    // Outputs are computed from next-state values so the registered outputs
    // change on the same edge as the state.
    always_comb begin
        number_d     = 14'd0;
        mode_d       = 2'd0;
        select_d     = 1'b0;
        go_d         = 1'b0;
        round_done_d = 1'b0;

        case (state_d)
            S_IDLE: mode_d = 2'd0;
            S_WAIT: mode_d = 2'd1;
            S_GO: begin
                mode_d   = 2'd2;
                go_d     = 1'b1;
                number_d = ms_d;
            end
            S_RESULT: begin
                mode_d   = 2'd3;
                select_d = view_d;
                number_d = view_d ? best_d : last_d;
            end
            S_FAULT: begin
                mode_d   = 2'd3;
                select_d = 1'b1;
            end
            default: mode_d = 2'd0;
        endcase

        if ((state_d == S_RESULT || state_d == S_FAULT) && state_d != state_q)
            round_done_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            sync1_q    <= 3'b000;
            sync2_q    <= 3'b000;
            prev_q     <= 3'b000;
            lfsr_q     <= LFSR_SEED;
            presc_q    <= '0;
            wait_q     <= 13'd0;
            ms_q       <= 14'd0;
            last_q     <= 14'd0;
            best_q     <= MS_MAX;
            view_q     <= 1'b0;
            number     <= 14'd0;
            mode       <= 2'd0;
            select     <= 1'b0;
            go         <= 1'b0;
            round_done <= 1'b0;
        end else begin
            state_q    <= state_d;
            sync1_q    <= {btnD, btnU, btnS};
            sync2_q    <= sync1_q;
            prev_q     <= sync2_q;
            lfsr_q     <= lfsr_d;
            presc_q    <= presc_d;
            wait_q     <= wait_d;
            ms_q       <= ms_d;
            last_q     <= last_d;
            best_q     <= best_d;
            view_q     <= view_d;
            number     <= number_d;
            mode       <= mode_d;
            select     <= select_d;
            go         <= go_d;
            round_done <= round_done_d;
        end
    end

endmodule

// File: tb/tb_reaction_controller.sv
// ---------------------------------------------------------------------------
// tb_reaction_controller
//
// Directed bench for reaction_controller with TICK_DIV=4, MIN_WAIT_MS=2.
// Round outcomes are pushed to exp_q as {mode, select, number} before the
// deciding press; a monitor pops one entry on every round_done pulse.
// Inputs are driven on the falling edge; outputs are sampled on the
// falling edge.
// ---------------------------------------------------------------------------
module tb_reaction_controller;

    localparam int TICK_DIV    = 4;
    localparam int MIN_WAIT_MS = 2;
    localparam int GO_BOUND    = TICK_DIV * (MIN_WAIT_MS + 4096) + 20;

    // ---------------- clock / reset ----------------
    logic clk  = 1'b0;
    logic rst  = 1'b0;
    logic btnS = 1'b0;
    logic btnU = 1'b0;
    logic btnD = 1'b0;

    logic [13:0] number;
    logic [1:0]  mode;
    logic        select;
    logic        go;
    logic        round_done;

    always #5 clk = ~clk;

    reaction_controller #(
        .TICK_DIV   (TICK_DIV),
        .MIN_WAIT_MS(MIN_WAIT_MS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .btnS      (btnS),
        .btnU      (btnU),
        .btnD      (btnD),
        .number    (number),
        .mode      (mode),
        .select    (select),
        .go        (go),
        .round_done(round_done)
    );

    initial begin
        #(10 * 300000);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- bookkeeping ----------------
    int          n_checks = 0;
    int          n_pass   = 0;
    logic [16:0] exp_q[$];
    logic        prev_rd  = 1'b0;
    logic        go_seen  = 1'b0;
    logic [15:0] lfsr_m;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Reference LFSR: x^16+x^14+x^13+x^11+1 Galois form, seed ACE1.
    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        return {1'b0, v[15:1]} ^ (v[0] ? 16'hB400 : 16'h0000);
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) lfsr_m <= 16'hACE1;
        else      lfsr_m <= lfsr_next(lfsr_m);
    end

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        logic [16:0] e;
        if (!rst) begin
            prev_rd = 1'b0;
        end else begin
            if (go) go_seen = 1'b1;
            if (prev_rd) check("round_done_width", {31'd0, round_done}, 32'd0);
            if (round_done) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL round_result: unexpected round_done mode=%0d select=%0d number=%0d",
                             mode, select, number);
                end else begin
                    e = exp_q.pop_front();
                    check("round_result", {15'd0, mode, select, number}, {15'd0, e});
                end
            end
            prev_rd = round_done;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic push_exp(input logic sel, input logic [13:0] num);
        exp_q.push_back({2'd3, sel, num});
    endtask

    // b: 0 = btnS, 1 = btnU, 2 = btnD, 3 = btnU and btnD together.
    task automatic press(input int b);
        case (b)
            0: btnS = 1'b1;
            1: btnU = 1'b1;
            2: btnD = 1'b1;
            default: begin btnU = 1'b1; btnD = 1'b1; end
        endcase
        repeat (3) @(negedge clk);
        btnS = 1'b0;
        btnU = 1'b0;
        btnD = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    // Waits until the LFSR value captured by a press made now has a small
    // low field (keeps the random delay short), then presses btnS and
    // checks the two-clock latency into WAIT. Returns the expected delay.
    task automatic start_round(output int w);
        logic [15:0] peek;
        int guard;
        guard = 0;
        peek  = lfsr_next(lfsr_next(lfsr_m));
        while (peek[11:0] >= 12'd64 && guard < 20000) begin
            @(negedge clk);
            guard++;
            peek = lfsr_next(lfsr_next(lfsr_m));
        end
        if (guard >= 20000) begin
            n_checks++;
            $display("FAIL lfsr_search: no short delay found in %0d cycles", guard);
        end
        w = MIN_WAIT_MS + int'(peek[11:0]);
        btnS = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("idle_hold", {30'd0, mode}, 32'd0);
        @(negedge clk);
        check("enter_wait", {30'd0, mode}, 32'd1);
        btnS = 1'b0;
    endtask

    task automatic wait_go(input int w);
        int c;
        c = 0;
        while (c < GO_BOUND && go !== 1'b1) begin
            @(negedge clk);
            c++;
        end
        check("go_delay", c, TICK_DIV * w);
        check("go_mode", {30'd0, mode}, 32'd2);
    endtask

    // Releases a press that is synchronized after exactly n ticks in GO.
    task automatic hold_and_react(input int n);
        repeat (TICK_DIV * 2) @(negedge clk);
        check("go_live", {18'd0, number}, 32'd2);
        repeat (TICK_DIV * n - TICK_DIV * 2) @(negedge clk);
        push_exp(1'b0, 14'(n));
        press(0);
        check("result_number", {18'd0, number}, n);
        check("result_select", {31'd0, select}, 32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int w;
        int c;

        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rst_number", {18'd0, number}, 32'd0);
        check("rst_mode", {30'd0, mode}, 32'd0);
        check("rst_select", {31'd0, select}, 32'd0);
        check("rst_go", {31'd0, go}, 32'd0);
        check("rst_round_done", {31'd0, round_done}, 32'd0);

        // Normal round, 5 ms reaction.
        start_round(w);
        wait_go(w);
        hold_and_react(5);
        press(1);
        check("best_view_5", {18'd0, number}, 32'd5);
        check("best_view_5_sel", {31'd0, select}, 32'd1);
        press(0);
        check("back_idle_1", {30'd0, mode}, 32'd0);

        // False start, then U/D ignored in FAULT.
        start_round(w);
        repeat (3) @(negedge clk);
        push_exp(1'b1, 14'd0);
        press(0);
        press(1);
        press(2);
        check("fault_mode", {30'd0, mode}, 32'd3);
        check("fault_select", {31'd0, select}, 32'd1);
        check("fault_number", {18'd0, number}, 32'd0);
        press(0);
        check("back_idle_2", {30'd0, mode}, 32'd0);

        // Reset in the middle of GO.
        start_round(w);
        wait_go(w);
        repeat (10) @(negedge clk);
        rst = 1'b0;
        #1;
        check("midrst_number", {18'd0, number}, 32'd0);
        check("midrst_mode", {30'd0, mode}, 32'd0);
        check("midrst_select", {31'd0, select}, 32'd0);
        check("midrst_go", {31'd0, go}, 32'd0);
        check("midrst_round_done", {31'd0, round_done}, 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Timeout round: best must still read 9999 (lost on reset).
        start_round(w);
        wait_go(w);
        push_exp(1'b0, 14'd9999);
        c = 0;
        while (c < TICK_DIV * 10000 && mode !== 2'd3) begin
            @(negedge clk);
            c++;
        end
        check("timeout_cycles", c, TICK_DIV * 9999);
        check("timeout_number", {18'd0, number}, 32'd9999);
        repeat (3) @(negedge clk);
        press(1);
        check("best_after_reset", {18'd0, number}, 32'd9999);
        check("best_after_reset_sel", {31'd0, select}, 32'd1);
        press(0);

        // Best tracking: 7 ms then 12 ms.
        start_round(w);
        wait_go(w);
        hold_and_react(7);
        press(0);
        start_round(w);
        wait_go(w);
        hold_and_react(12);
        press(1);
        check("best_7", {18'd0, number}, 32'd7);
        check("best_7_sel", {31'd0, select}, 32'd1);
        press(2);
        check("best_cleared", {18'd0, number}, 32'd9999);
        press(1);
        check("last_12", {18'd0, number}, 32'd12);
        check("last_12_sel", {31'd0, select}, 32'd0);
        press(3);
        check("ud_together", {18'd0, number}, 32'd9999);
        check("ud_together_sel", {31'd0, select}, 32'd1);
        press(0);
        check("back_idle_3", {30'd0, mode}, 32'd0);

        // Press synchronized on the exact cycle the wait expires.
        start_round(w);
        go_seen = 1'b0;
        repeat (TICK_DIV * w - 3) @(negedge clk);
        push_exp(1'b1, 14'd0);
        press(0);
        check("coincide_no_go", {31'd0, go_seen}, 32'd0);
        check("coincide_mode", {30'd0, mode}, 32'd3);
        check("coincide_select", {31'd0, select}, 32'd1);
        press(0);
        check("back_idle_4", {30'd0, mode}, 32'd0);

        // ---------------- final report ----------------
        repeat (5) @(negedge clk);
        check("exp_q_empty", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/reaction_controller.md
# reaction_controller

Round sequencer for the FPGA reaction game. It detects the player's button presses and runs each round: arm, random delay, "go", reaction-time measurement in milliseconds, and result or false-start reporting. It drives the `number` / `mode` / `select` inputs of the existing `display` block, so it stands where the game `logic` instance sits in `top_level`.

## Interface
- `TICK_DIV`, default 100000: clk cycles per 1 ms tick (100 MHz board).
- `MIN_WAIT_MS`, default 1000: minimum random delay before "go", in ms.
- `clk` input 1: system clock, all state on its rising edge.
- `rst` input 1: asynchronous, active-low reset. Assertion forces all state to reset values immediately. Release is synchronous to `clk`.
- `btnS` input 1: start / react / acknowledge. Debounced upstream, asynchronous to `clk`.
- `btnU` input 1: toggles result view between last time and best time.
- `btnD` input 1: clears best time.
- `number` output 14: value for the display, 0..9999.
- `mode` output 2: 0 = IDLE, 1 = WAIT, 2 = GO, 3 = RESULT/FAULT.
- `select` output 1: in mode 3, 1 means fault (display blinks) or best-time view.
- `go` output 1: high only in GO state (stimulus LED).
- `round_done` output 1: one-cycle pulse on entry to RESULT or FAULT.

## Operation
- **Inputs:** each button passes through a 2-FF synchronizer and then a rising-edge detector (`sync2 & ~prev`). Only edges are acted on; held buttons do nothing further.
- **LFSR:** 16-bit Galois LFSR, polynomial x^16+x^14+x^13+x^11+1.
  - Reset seed is 16'hACE1. It advances every clk and never reaches zero.
- **Tick:** prescaler counts 0..TICK_DIV-1 and pulses `tick` at TICK_DIV-1.
  - Cleared on every state change, so the first ms of each state is a full ms.
- **IDLE** (mode 0, `number` = 0, `select` = 0)
  - btnS edge: `wait_ms` ← MIN_WAIT_MS + lfsr[11:0] (range MIN..MIN+4095, 13-bit), then go to WAIT.
- **WAIT** (mode 1, `number` = 0)
  - Each tick decrements `wait_ms`.
  - Tick with `wait_ms` == 1: go to GO, `ms_cnt` ← 0.
  - btnS edge: go to FAULT. This also applies when it coincides with expiry; the fault wins.
- **GO** (mode 2, `go` = 1, `number` = `ms_cnt`, shown live)
  - Each tick increments `ms_cnt`, 14-bit.
  - btnS edge: `last` ← `ms_cnt` (pre-increment value if a tick coincides), then go to RESULT.
  - Tick with `ms_cnt` == 9998: `ms_cnt` ← 9999, `last` ← 9999 (timeout), then go to RESULT.
  - btnS edge on that same cycle wins and latches 9998.
- **RESULT** (mode 3)
  - On entry: if `last` < `best`, then `best` ← `last`. The view flag is cleared.
  - `number` = view ? `best` : `last`, and `select` = view.
  - btnU edge toggles the view.
  - btnD edge sets `best` ← 9999. If btnU and btnD edges arrive together, both apply.
  - btnS edge: go to IDLE.
- **FAULT** (mode 3, `number` = 0, `select` = 1)
  - btnS edge: go to IDLE. btnU and btnD are ignored.
- btnU and btnD are ignored outside RESULT. An edge on more than one button at once in other states acts only on btnS.

## Timing
- **Reset values:**
  - state IDLE; `number` 0, `mode` 0, `select` 0, `go` 0, `round_done` 0.
  - `best` 9999, `last` 0, `ms_cnt` 0, `wait_ms` 0, prescaler 0, LFSR 16'hACE1, synchronizers 0.
- **Button latency:** a button pin high before clk edge k causes the state change at edge k+2.
- **Outputs:** all outputs are registered and change at the same edge as the state.
- **`round_done`:** high for exactly one cycle, aligned with the first cycle in RESULT/FAULT.
- **Measured value:** N means btnS was synchronized after N complete ticks in GO, so the error is under 1 ms plus 2 cycles.
- **Reset mid-round:** returns to IDLE immediately and loses `best`.

## Test plan
- **Reset:** TICK_DIV=4, MIN_WAIT_MS=2, `rst` low mid-GO → all outputs at reset values at once; `best` reads 9999 in a later RESULT best view.
- **Normal round:**
  - Press btnS in IDLE → mode 1 after 2 clks.
  - `go` rises after (2 + lfsr[11:0] at capture) ticks.
  - Press btnS 5 ticks after `go` → mode 3, `number` 5, `select` 0, one `round_done` pulse.
- **False start:** btnS in WAIT → mode 3, `select` 1, `number` 0. Next btnS → mode 0.
- **Timeout:** no press in GO → after 9999 ticks, mode 3, `number` 9999, `best` unchanged at 9999.
- **Best tracking:**
  - Rounds of 7 then 12 ms, then btnU → `number` 7, `select` 1.
  - btnD → `number` 9999. btnU again → `number` 12, `select` 0.
- **Coincidence:** btnS edge on the same cycle as WAIT expiry → FAULT, never GO.
